// File: rtl/pipe_alu_stream.sv
// Two-stage pipelined ALU with valid/ready on both sides. A one-hot opcode is
// encoded ahead of S1, and the ALU sits between S1 and S2. S2 drives all outputs except in_ready.
module pipe_alu_stream #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             clear_pipeline,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       op_onehot,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             carry,
   output logic             zero,
   output logic             parity,
   output logic             err,
   output logic [TAG_W-1:0] tag_out
);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [2:0] OP_NOR  = 3'd5;
   localparam logic [2:0] OP_NAND = 3'd6;
   localparam logic [2:0] OP_XNOR = 3'd7;

   logic             r_s1_valid;
   logic [2:0]       r_s1_op;
   logic             r_s1_err;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [TAG_W-1:0] r_s1_tag;

   logic             r_s2_valid;
   logic [WIDTH-1:0] r_s2_res;
   logic             r_s2_carry;
   logic             r_s2_zero;
   logic             r_s2_parity;
   logic             r_s2_err;
   logic [TAG_W-1:0] r_s2_tag;

   logic             w_s1_load;
   logic             w_s2_load;
   logic             w_one_hot;
   logic [2:0]       w_op_enc;
   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic [WIDTH-1:0] w_res;
   logic             w_carry;
   logic             w_zero;
   logic             w_parity;

   // S2 frees up when it is empty or its result leaves this cycle, which lets S1
   // drain and refill on the same edge.
   assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
   assign in_ready  = !r_s1_valid || w_s2_load;
   assign w_s1_load = in_valid && in_ready;

   assign w_one_hot = (op_onehot != 8'd0) && ((op_onehot & (op_onehot - 8'd1)) == 8'd0);

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
      w_op_enc = OP_ADD;
      if (w_one_hot) begin
         for (int k = 0; k < 8; k++) begin
            if (op_onehot[k]) w_op_enc = 3'(k);
         end
      end
   end

   assign w_add = {1'b0, r_s1_a} + {1'b0, r_s1_b};
   assign w_sub = {1'b0, r_s1_a} + {1'b0, ~r_s1_b} + {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      w_res   = '0;
      w_carry = 1'b0;
      case (r_s1_op)
         OP_ADD:  {w_carry, w_res} = w_add;
         OP_SUB:  {w_carry, w_res} = w_sub;
         OP_XOR:  w_res = r_s1_a ^ r_s1_b;
         OP_OR:   w_res = r_s1_a | r_s1_b;
         OP_AND:  w_res = r_s1_a & r_s1_b;
         OP_NOR:  w_res = ~(r_s1_a | r_s1_b);
         OP_NAND: w_res = ~(r_s1_a & r_s1_b);
         OP_XNOR: w_res = ~(r_s1_a ^ r_s1_b);
         default: w_res = '0;
      endcase
   end

   assign w_zero   = (w_res == '0);
   assign w_parity = ^{w_carry, w_res};

   always_ff @(posedge clk or negedge clear_pipeline) begin
      // NOTE: the data registers are reset along with the valids, so outputs read 0 during and after reset.
      if (!clear_pipeline) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= '0;
         r_s1_err   <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_tag   <= '0;
      end else if (w_s1_load) begin
         // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
         r_s1_valid <= 1'b1;
         r_s1_op    <= w_op_enc;
         r_s1_err   <= !w_one_hot;
         r_s1_a     <= a;
         r_s1_b     <= b;
         r_s1_tag   <= tag_in;
      end else if (w_s2_load) begin
         r_s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge clear_pipeline) begin
      if (!clear_pipeline) begin
         r_s2_valid  <= 1'b0;
         r_s2_res    <= '0;
         r_s2_carry  <= 1'b0;
         r_s2_zero   <= 1'b0;
         r_s2_parity <= 1'b0;
         r_s2_err    <= 1'b0;
         r_s2_tag    <= '0;
      end else if (w_s2_load) begin
         r_s2_valid  <= 1'b1;
         r_s2_res    <= w_res;
         r_s2_carry  <= w_carry;
         r_s2_zero   <= w_zero;
         r_s2_parity <= w_parity;
         r_s2_err    <= r_s1_err;
         r_s2_tag    <= r_s1_tag;
      end else if (r_s2_valid && out_ready) begin
         r_s2_valid <= 1'b0;
      end
   end

   assign out_valid = r_s2_valid;
   assign res       = r_s2_res;
   assign carry     = r_s2_carry;
   assign zero      = r_s2_zero;
   assign parity    = r_s2_parity;
   assign err       = r_s2_err;
   assign tag_out   = r_s2_tag;

endmodule

// File: tb/tb_pipe_alu_stream.sv
// Directed bench for pipe_alu_stream. Expected results are queued when a
// transaction is accepted and compared when the consumer takes the output.
module tb_pipe_alu_stream;

   typedef struct packed {
      logic [7:0] res;
      logic       carry;
      logic       zero;
      logic       parity;
      logic       err;
      logic [3:0] tag;
   } exp_t;

   logic       clk;
   logic       clear_pipeline;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] op_onehot;
   logic [7:0] a;
   logic [7:0] b;
   logic [3:0] tag_in;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] res;
   logic       carry;
   logic       zero;
   logic       parity;
   logic       err;
   logic [3:0] tag_out;

   logic       in_valid4;
   logic       in_ready4;
   logic [7:0] op4;
   logic [3:0] a4;
   logic [3:0] b4;
   logic [3:0] tag4;
   logic       out_valid4;
   logic [3:0] res4;
   logic       carry4;
   logic       zero4;
   logic       parity4;
   logic       err4;
   logic [3:0] tag4_out;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   pipe_alu_stream #(.WIDTH(8), .TAG_W(4)) u_dut (
      .clk(clk), .clear_pipeline(clear_pipeline),
      .in_valid(in_valid), .in_ready(in_ready), .op_onehot(op_onehot),
      .a(a), .b(b), .tag_in(tag_in),
      .out_valid(out_valid), .out_ready(out_ready), .res(res), .carry(carry),
      .zero(zero), .parity(parity), .err(err), .tag_out(tag_out)
   );

   pipe_alu_stream #(.WIDTH(4), .TAG_W(4)) u_dut4 (
      .clk(clk), .clear_pipeline(clear_pipeline),
      .in_valid(in_valid4), .in_ready(in_ready4), .op_onehot(op4),
      .a(a4), .b(b4), .tag_in(tag4),
      .out_valid(out_valid4), .out_ready(1'b1), .res(res4), .carry(carry4),
      .zero(zero4), .parity(parity4), .err(err4), .tag_out(tag4_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] oh, input logic [7:0] x, input logic [7:0] y,
                                  input logic [3:0] t);
      exp_t       e;
      logic [8:0] wide;
      int         sel;
      logic       legal;
      legal = ($countones(oh) == 1);
      sel   = 0;
      if (legal) begin
         for (int k = 0; k < 8; k++) if (oh[k]) sel = k;
      end
      wide = 9'd0;
      case (sel)
         0: wide = {1'b0, x} + {1'b0, y};
         1: begin wide[7:0] = x - y; wide[8] = (x >= y); end
         2: wide[7:0] = x ^ y;
         3: wide[7:0] = x | y;
         4: wide[7:0] = x & y;
         5: wide[7:0] = ~(x | y);
         6: wide[7:0] = ~(x & y);
         7: wide[7:0] = ~(x ^ y);
         default: wide = 9'd0;
      endcase
      e.res    = wide[7:0];
      e.carry  = wide[8];
      e.zero   = (wide[7:0] == 8'd0);
      e.parity = ^wide;
      e.err    = !legal;
      e.tag    = t;
      return e;
   endfunction

   // Output side: every result the consumer takes must match the oldest expected entry.
   always @(negedge clk) begin
      if (clear_pipeline && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("spurious_output", 32'(out_valid), 32'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", 32'({res, carry, zero, parity, err, tag_out}), 32'(e));
         end
      end
   end

   task automatic send(input logic [7:0] oh, input logic [7:0] x, input logic [7:0] y,
                       input logic [3:0] t);
      int waited = 0;
      in_valid  = 1'b1;
      op_onehot = oh;
      a         = x;
      b         = y;
      tag_in    = t;
      @(negedge clk);
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("accept_timeout", 32'(in_ready), 32'(1));
      if (in_ready) sb.push_back(model(oh, x, y, t));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      check("drain", 32'(sb.size()), 32'(0));
   endtask

   initial begin
      logic [31:0] snap;
      clear_pipeline = 1'b0;
      in_valid = 1'b0; op_onehot = 8'd0; a = 8'd0; b = 8'd0; tag_in = 4'd0; out_ready = 1'b1;
      in_valid4 = 1'b0; op4 = 8'd0; a4 = 4'd0; b4 = 4'd0; tag4 = 4'd0;
      #2;
      check("reset_outputs", 32'({out_valid, res, carry, zero, parity, err, tag_out}), 32'(0));
      check("reset_in_ready", 32'(in_ready), 32'(1));
      check("reset_outputs_w4", 32'({out_valid4, res4, err4, tag4_out}), 32'(0));
      @(posedge clk);
      #1;
      clear_pipeline = 1'b1;

      // ADD with carry out, plus latency: empty after the accepting edge, valid after the next one.
      send(8'b0000_0001, 8'hF0, 8'h20, 4'h3);
      @(negedge clk);
      check("add_latency_early", 32'(out_valid), 32'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check("add_latency_due", 32'(out_valid), 32'(1));
      @(posedge clk); #1;

      // SUB equal then borrow, results on consecutive cycles.
      send(8'b0000_0010, 8'h05, 8'h05, 4'h4);
      send(8'b0000_0010, 8'h03, 8'h05, 4'h5);
      @(negedge clk);
      check("sub_first_valid", 32'({out_valid, tag_out}), 32'({1'b1, 4'h4}));
      @(posedge clk); #1;
      @(negedge clk);
      check("sub_second_valid", 32'({out_valid, tag_out}), 32'({1'b1, 4'h5}));
      @(posedge clk); #1;

      // Remaining ops with random operands, back to back.
      for (int k = 2; k < 8; k++) begin
         send(8'(1) << k, 8'($urandom), 8'($urandom), 4'(k));
      end
      wait_drain();

      // Illegal opcodes fall back to ADD with err set.
      send(8'b0000_0011, 8'h01, 8'h02, 4'hA);
      send(8'h00, 8'h33, 8'h44, 4'hB);
      wait_drain();

      // Backpressure: tags 1 and 2 fill the pipe, consumer stalls for 3 cycles.
      send(8'b0000_0001, 8'h10, 8'h20, 4'd1);
      send(8'b0000_0001, 8'h11, 8'h21, 4'd2);
      out_ready = 1'b0;
      in_valid  = 1'b1; op_onehot = 8'b0000_0001; a = 8'h12; b = 8'h22; tag_in = 4'd3;
      snap = 32'({out_valid, res, carry, zero, parity, err, tag_out});
      check("stall_head_tag", 32'({out_valid, tag_out}), 32'({1'b1, 4'd1}));
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 32'(0));
         check("stall_hold", 32'({out_valid, res, carry, zero, parity, err, tag_out}), snap);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      for (int i = 3; i <= 6; i++) begin
         in_valid = 1'b1; op_onehot = 8'b0000_0001;
         a = 8'(8'h0F + i); b = 8'(8'h1F + i); tag_in = 4'(i);
         @(negedge clk);
         check("release_in_ready", 32'(in_ready), 32'(1));
         check("release_order", 32'({out_valid, tag_out}), 32'({1'b1, 4'(i - 2)}));
         sb.push_back(model(op_onehot, a, b, tag_in));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      for (int j = 5; j <= 6; j++) begin
         @(negedge clk);
         check("release_tail", 32'({out_valid, tag_out}), 32'({1'b1, 4'(j)}));
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("release_empty", 32'(out_valid), 32'(0));
      wait_drain();

      // Reset between edges with both stages full.
      out_ready = 1'b0;
      send(8'b0000_0001, 8'h01, 8'h01, 4'd7);
      send(8'b0000_0010, 8'h09, 8'h03, 4'd8);
      check("pre_reset_full", 32'({out_valid, in_ready}), 32'({1'b1, 1'b0}));
      #1;
      clear_pipeline = 1'b0;
      #1;
      check("midreset_outputs", 32'({out_valid, res, carry, zero, parity, err, tag_out}), 32'(0));
      check("midreset_in_ready", 32'(in_ready), 32'(1));
      sb.delete();
      clear_pipeline = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("post_reset_idle", 32'(out_valid), 32'(0));
         @(posedge clk); #1;
      end
      send(8'b0001_0000, 8'h3C, 8'h0F, 4'd9);
      @(negedge clk);
      check("post_reset_latency_early", 32'(out_valid), 32'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check("post_reset_latency_due", 32'({out_valid, tag_out}), 32'({1'b1, 4'd9}));
      @(posedge clk); #1;

      // 4-bit instance, XNOR.
      in_valid4 = 1'b1; op4 = 8'b1000_0000; a4 = 4'hF; b4 = 4'hA; tag4 = 4'h6;
      @(negedge clk);
      check("w4_in_ready", 32'(in_ready4), 32'(1));
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      @(negedge clk);
      check("w4_latency_early", 32'(out_valid4), 32'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check("w4_xnor", 32'({out_valid4, res4, carry4, zero4, parity4, err4, tag4_out}),
            32'({1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6}));

      wait_drain();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within the time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
